// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select and imem handshake.
// Feeds instruction, PC+4 and hold/flush controls into the IF/ID register.
module if_fetch_unit #(
  parameter int                 IMEM_AW  = 32,
  parameter logic [IMEM_AW-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [IMEM_AW-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic [IMEM_AW-1:0] i_jump_target,
  output logic               o_imem_req,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic               i_imem_ready,
  input  logic [31:0]        i_imem_rdata,
  output logic [IMEM_AW-1:0] o_pc,
  output logic [IMEM_AW-1:0] o_PCplus4,
  output logic [31:0]        o_instr,
  output logic               o_no_change,
  output logic               o_IF_flush
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t             state;
  logic [IMEM_AW-1:0] pc;
  logic [IMEM_AW-1:0] redir_pc;
  logic [31:0]        buf_q;

  logic               redirect;
  logic [IMEM_AW-1:0] target;
  logic [IMEM_AW-1:0] pc_inc;
  logic               deliver;
  logic [31:0]        word;

  assign redirect = (i_branch_taken | i_jump) & ~i_stall;
  assign target   = i_branch_taken ? i_branch_target
                                   : i_jump_target;
  assign pc_inc   = pc + IMEM_AW'(4);

  assign o_pc        = pc;
  assign o_PCplus4   = pc_inc;
  assign o_imem_addr = pc;

  // Decode request, delivery and IF/ID controls from the current state
  always_comb begin
    o_imem_req = 1'b0;
    deliver    = 1'b0;
    word       = buf_q;
    unique case (1'b1)
      (state == S_FETCH): begin
        o_imem_req = 1'b1;
        deliver    = i_imem_ready & ~i_stall & ~redirect;
        word       = i_imem_rdata;
      end
      (state == S_DRAIN): begin
        o_imem_req = 1'b1;
      end
      (state == S_HOLD): begin
        deliver = ~i_stall & ~redirect;
      end
      default: begin
        o_imem_req = 1'b0;
      end
    endcase
    o_no_change = ~deliver;
    o_instr     = deliver ? word : 32'h0;
    if (deliver)
      o_IF_flush = 1'b0;
    else if (state == S_IDLE)
      o_IF_flush = 1'b1;
    else
      o_IF_flush = ~i_stall;
  end

  // Fetch state machine with PC, stall buffer and pending-redirect target
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      buf_q    <= 32'h0;
      redir_pc <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (i_imem_ready) begin
            if (redirect) begin
              pc <= target;
            end else if (i_stall) begin
              buf_q <= i_imem_rdata;
              state <= S_HOLD;
            end else begin
              pc <= pc_inc;
            end
          end else if (redirect) begin
            redir_pc <= target;
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (redirect)
            redir_pc <= target;
          if (i_imem_ready) begin
            pc    <= redirect ? target : redir_pc;
            state <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            pc    <= redirect ? target : pc_inc;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
